clkdiv_prog_ctrl: RTL

- Programmable divide-by-N clock generator with controller. Output is 50% duty for both odd and even N.
- Sequences the divider: start/stop control and handshake-based ratio reconfiguration.
- Ratio changes take effect only at output-period boundaries, so clk_out has no glitches or runt pulses.
- Drives divided clocks and period strobes for downstream FeFET programming-pulse timing logic.

---
 rtl/clkdiv_prog_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/clkdiv_prog_ctrl.sv
// Programmable divide-by-N clock generator with run/drain sequencing and a ratio-change handshake.
// Ratio updates are deferred to output-period boundaries so clk_out never glitches.
module clkdiv_prog_ctrl #(
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             period_tick,
   output logic             active,
   output logic [DIV_W-1:0] cur_div
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   logic             cfg_err_q, cfg_err_d;
   logic             pos_hi_q, pos_hi_d;
   logic             neg_hi_q;
   logic             last;
   logic             xfer;
   logic             cfg_legal;

   // High-phase length ceil(N/2), one bit wider so N = 2^DIV_W-1 cannot overflow.
   function automatic logic [DIV_W:0] half_ratio(input logic [DIV_W-1:0] n);
      return ({1'b0, n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_div_d    = cur_div_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;

      last        = (cnt_q == (cur_div_q - DIV_W'(1)));
      active      = (state_q != ST_IDLE);
      period_tick = active & last;
      cfg_ready   = ~pend_valid_q;
      xfer        = cfg_valid & cfg_ready;
      cfg_legal   = (cfg_div >= DIV_W'(2));
      cfg_err_d   = xfer & ~cfg_legal;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = last ? '0 : cnt_q + DIV_W'(1);
            if (!en) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            cnt_d = last ? '0 : cnt_q + DIV_W'(1);
            if (en)        state_d = ST_RUN;
            else if (last) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // A pending ratio is only consumed at a period boundary (or straight away when stopped).
      if (pend_valid_q && (period_tick || !active)) begin
         cur_div_d    = pend_q;
         pend_valid_d = 1'b0;
      end

      if (xfer && cfg_legal) begin
         if (!active) begin
            cur_div_d = cfg_div;
         end else begin
            pend_d       = cfg_div;
            pend_valid_d = 1'b1;
         end
      end

      pos_hi_d = (state_d != ST_IDLE) && ({1'b0, cnt_d} < half_ratio(cur_div_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cur_div_q    <= DIV_W'(DEFAULT_DIV);
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         pos_hi_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_div_q    <= cur_div_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         cfg_err_q    <= cfg_err_d;
         pos_hi_q     <= pos_hi_d;
      end
   end

   // Half-cycle delayed copy gives odd ratios their extra half clock of low time.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) neg_hi_q <= 1'b0;
      else        neg_hi_q <= pos_hi_q;
   end

   assign clk_out = cur_div_q[0] ? (pos_hi_q & neg_hi_q) : pos_hi_q;
   assign cur_div = cur_div_q;
   assign cfg_err = cfg_err_q;

endmodule
